delay_tap_ctrl: RTL
===================

Name: delay_tap_ctrl

Overview:
- Sequencer for the 32-tap inverter-chain delay buffer. Drives the buffer's 5-bit mux select.
- Tap changes are made one step at a time. A settle interval follows each step, so the mux output never jumps across many taps in one cycle.
- Also runs a calibration sweep: it finds the first tap at which a sampled, delayed signal flips from 0 to 1 and reports that tap.
- Sits between the register/config logic and the delay buffer instance.

Parameters:
TAP_W, 5, select width; tap count NUM_TAPS = 2^TAP_W
SETTLE_CYCLES, 4, idle cycles after each single-tap step before the next action (>=1)
RESET_TAP, 0, tap driven on sel while in reset and after reset

Ports:
clock  in  1  sole clock
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  move request valid
req_ready  out  1  move request accepted when req_valid && req_ready
req_tap  in  TAP_W  target tap for move request
cal_start  in  1  single-cycle calibration start; honoured only in IDLE
cal_sample  in  1  synchronised sample of the delayed signal against the reference edge
sel  out  TAP_W  tap select to the delay buffer mux
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when a move or calibration completes
cal_valid  out  1  one-cycle pulse, coincident with done, for calibration only
cal_found  out  1  result of last calibration; held until the next calibration completes
cal_tap  out  TAP_W  transition tap from last calibration; held

Behaviour:
- Reset (async, reset_n low):
  - sel=RESET_TAP; state=IDLE.
  - done, cal_valid, cal_found, cal_tap, busy all 0.
  - Reset mid-operation aborts immediately; no done pulse is issued.
- req_ready = (state==IDLE) && !cal_start (combinational). If cal_start and req_valid are both high in IDLE, calibration wins and the request stays pending.
- FSM states: IDLE, STEP, SETTLE, SAMPLE, DONE.
- Move operation:
  - Request accepted in cycle t; target latched.
  - STEP: sel moves one tap toward target (+1 or -1). Then SETTLE holds for SETTLE_CYCLES cycles. Repeat until sel==target.
  - DONE lasts 1 cycle with done=1, then returns to IDLE.
  - For distance d, done is high in cycle t + d*(SETTLE_CYCLES+1) + 1. For d=0, done is in t+1 and sel is unchanged.
- sel never wraps. Each change is exactly ±1, and sel stays within 0..NUM_TAPS-1.
- Calibration operation:
  1. Latch the original tap.
  2. Walk stepwise down to tap 0.
  3. At each tap, after settle, SAMPLE cal_sample for one cycle.
  4. Record the previous sample. A transition is prev=0, cur=1 at tap k>0.
  5. On a transition: cal_found=1, cal_tap=k, and sel stays at k.
  6. If no transition is found by tap NUM_TAPS-1: cal_found=0, cal_tap=0, and sel walks stepwise back to the original tap.
  7. DONE: done=1 and cal_valid=1 for one cycle.
- The sample at tap 0 only seeds prev. A 1 at tap 0 is never a transition.
- cal_start outside IDLE is ignored. req_valid outside IDLE is back-pressured.

Optional Feature:
- Macro DELAY_TAP_CTRL_VOTE_EN.
- Defined: SAMPLE lasts 3 cycles and uses the 2-of-3 majority of cal_sample. Each sampled tap adds 2 cycles of latency.
- Undefined: SAMPLE lasts 1 cycle with a single raw sample.
- Move timing is identical in both builds.

Decomposition:
- Package delay_tap_pkg holds:
  - TAP_W and NUM_TAPS constants
  - state enum typedef (IDLE/STEP/SETTLE/SAMPLE/DONE)
  - tap_t typedef
  - op typedef (MOVE/CAL)
- One sub-module, delay_tap_stepper:
  - holds sel and the settle counter
  - inputs: target, go; outputs: at_target, settled
  - the top-level FSM sequences it for move, sweep and restore.

Test Plan:
- Reset: reset_n low -> sel=0, busy=0, req_ready=1, done=0. Release -> values unchanged.
- Move 0->3 accepted at cycle t (SETTLE_CYCLES=4) -> sel goes 1,2,3 at 5-cycle spacing; done pulses in cycle t+16; every sel change is exactly ±1.
- Move from sel=3 to req_tap=3 -> done in t+1, sel stays 3. cal_start and req_valid together in IDLE -> calibration starts, req_ready=0.
- Calibration from sel=5, cal_sample=1 iff sel>=12 -> sel walks down to 0, then sweeps up; cal_found=1, cal_tap=12, sel ends at 12; cal_valid and done high in the same single cycle.
- Calibration from sel=5, cal_sample always 0 -> sweep reaches 31; cal_found=0, cal_tap=0; sel walks back to 5, then done.
- Move toward 20, reset_n low when sel=7 -> sel=0 immediately, no done, req_ready=1 after release. With DELAY_TAP_CTRL_VOTE_EN, a single-cycle glitch on cal_sample during SAMPLE is rejected.

Source files
------------

// File: rtl/delay_tap_pkg.sv
// Shared types and constants for the delay-buffer tap sequencer.
//   TAP_W / NUM_TAPS : select width and tap count of the inverter-chain buffer
//   tap_t            : one tap index
//   state_t          : sequencer FSM states
//   op_t             : operation in progress (move or calibration)
//   phase_t          : sub-phase used to sequence moves, sweep and restore
//   majority3        : 2-of-3 vote used by the optional sample filter
package delay_tap_pkg;

  localparam int TAP_W    = 5;
  localparam int NUM_TAPS = 1 << TAP_W;

  typedef logic [TAP_W-1:0] tap_t;

  localparam tap_t TAP_MAX = tap_t'(NUM_TAPS - 1);

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  typedef enum logic {
    MOVE,
    CAL
  } op_t;

  typedef enum logic [1:0] {
    PH_MOVE,
    PH_DOWN,
    PH_SWEEP,
    PH_RESTORE
  } phase_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/delay_tap_stepper.sv
// Single-step tap mover with settle timer.
//   clock, reset_n : clock and asynchronous active-low reset
//   target         : tap the mover heads toward
//   go             : take one step (+1/-1) toward target and restart the settle timer
//   sel            : current tap select driven to the delay buffer mux
//   at_target      : sel equals target
//   settled        : settle timer expired (a SETTLE cycle with this high is the last one)
module delay_tap_stepper
  import delay_tap_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int RESET_TAP     = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [TAP_W-1:0] target,
  input  logic             go,
  output logic [TAP_W-1:0] sel,
  output logic             at_target,
  output logic             settled
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Loading SETTLE_CYCLES-1 makes the settle window exactly SETTLE_CYCLES cycles
  // long, with settled high in its final cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel <= tap_t'(RESET_TAP);
      cnt <= '0;
    end else if (go) begin
      cnt <= CNT_LOAD;
      if (target > sel) begin
        sel <= sel + 1'b1;
      end else if (target < sel) begin
        sel <= sel - 1'b1;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign at_target = (sel == target);
  assign settled   = (cnt == '0);

endmodule

// File: rtl/delay_tap_ctrl.sv
// Tap sequencer for the 32-tap inverter-chain delay buffer.
// Moves the mux select one tap at a time with a settle interval after each step,
// and runs a calibration sweep that finds the first 0->1 transition of cal_sample.
// Optional build macro: DELAY_TAP_CTRL_VOTE_EN (3-cycle SAMPLE with 2-of-3 vote).
//   clock, reset_n   : clock and asynchronous active-low reset
//   req_valid/ready  : move request handshake, req_tap is the target tap
//   cal_start        : one-cycle calibration start, honoured only in IDLE
//   cal_sample       : synchronised sample of the delayed signal
//   sel              : tap select to the delay buffer
//   busy             : sequencer not idle
//   done             : one-cycle completion pulse (move or calibration)
//   cal_valid        : one-cycle pulse with done, calibration only
//   cal_found/cal_tap: held result of the last calibration
module delay_tap_ctrl
  import delay_tap_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int RESET_TAP     = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAP_W-1:0] req_tap,
  input  logic             cal_start,
  input  logic             cal_sample,
  output logic [TAP_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic             cal_valid,
  output logic             cal_found,
  output logic [TAP_W-1:0] cal_tap
);

  state_t state, state_d;
  op_t    op, op_d;
  phase_t phase, phase_d;
  tap_t   target, target_d;
  tap_t   orig, orig_d;
  logic   prev, prev_d;
  logic   found_q, found_d;
  tap_t   ctap_q, ctap_d;
  logic   go;
  logic   at_target;
  logic   settled;
  logic   sample_ready;
  logic   sample_bit;

`ifdef DELAY_TAP_CTRL_VOTE_EN
  logic [1:0] vcnt, vcnt_d;
  logic [1:0] vbits, vbits_d;
`endif

  delay_tap_stepper #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .RESET_TAP    (RESET_TAP)
  ) u_stepper (
    .clock    (clock),
    .reset_n  (reset_n),
    .target   (target),
    .go       (go),
    .sel      (sel),
    .at_target(at_target),
    .settled  (settled)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op      <= MOVE;
      phase   <= PH_MOVE;
      target  <= tap_t'(RESET_TAP);
      orig    <= tap_t'(RESET_TAP);
      prev    <= 1'b0;
      found_q <= 1'b0;
      ctap_q  <= '0;
`ifdef DELAY_TAP_CTRL_VOTE_EN
      vcnt    <= '0;
      vbits   <= '0;
`endif
    end else begin
      op      <= op_d;
      phase   <= phase_d;
      target  <= target_d;
      orig    <= orig_d;
      prev    <= prev_d;
      found_q <= found_d;
      ctap_q  <= ctap_d;
`ifdef DELAY_TAP_CTRL_VOTE_EN
      vcnt    <= vcnt_d;
      vbits   <= vbits_d;
`endif
    end
  end

  always_comb begin
    state_d  = state;
    op_d     = op;
    phase_d  = phase;
    target_d = target;
    orig_d   = orig;
    prev_d   = prev;
    found_d  = found_q;
    ctap_d   = ctap_q;
    go       = 1'b0;
`ifdef DELAY_TAP_CTRL_VOTE_EN
    vcnt_d       = vcnt;
    vbits_d      = vbits;
    sample_ready = (vcnt == 2'd2);
    sample_bit   = majority3(vbits[0], vbits[1], cal_sample);
`else
    sample_ready = 1'b1;
    sample_bit   = cal_sample;
`endif

    case (state)
      IDLE: begin
        if (cal_start) begin
          op_d   = CAL;
          orig_d = sel;
          prev_d = 1'b0;
          if (sel == '0) begin
            phase_d  = PH_SWEEP;
            target_d = TAP_MAX;
            state_d  = SAMPLE;
          end else begin
            phase_d  = PH_DOWN;
            target_d = '0;
            state_d  = STEP;
          end
        end else if (req_valid) begin
          op_d     = MOVE;
          phase_d  = PH_MOVE;
          target_d = req_tap;
          state_d  = (req_tap == sel) ? DONE : STEP;
        end
      end

      STEP: begin
        go      = 1'b1;
        state_d = SETTLE;
      end

      SETTLE: begin
        if (settled) begin
          case (phase)
            PH_MOVE: state_d = at_target ? DONE : STEP;
            PH_DOWN: begin
              if (at_target) begin
                phase_d  = PH_SWEEP;
                target_d = TAP_MAX;
                state_d  = SAMPLE;
              end else begin
                state_d = STEP;
              end
            end
            PH_SWEEP: state_d = SAMPLE;
            PH_RESTORE: begin
              if (at_target) begin
                found_d = 1'b0;
                ctap_d  = '0;
                state_d = DONE;
              end else begin
                state_d = STEP;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end

      SAMPLE: begin
`ifdef DELAY_TAP_CTRL_VOTE_EN
        if (!sample_ready) begin
          vbits_d[vcnt[0]] = cal_sample;
          vcnt_d           = vcnt + 2'd1;
        end else begin
          vcnt_d = '0;
        end
`endif
        if (sample_ready) begin
          if ((sel != '0) && !prev && sample_bit) begin
            found_d = 1'b1;
            ctap_d  = sel;
            state_d = DONE;
          end else begin
            prev_d = sample_bit;
            if (sel == TAP_MAX) begin
              // No transition anywhere: walk back; the 0/0 result is committed on arrival.
              phase_d  = PH_RESTORE;
              target_d = orig;
              if (orig == TAP_MAX) begin
                found_d = 1'b0;
                ctap_d  = '0;
                state_d = DONE;
              end else begin
                state_d = STEP;
              end
            end else begin
              state_d = STEP;
            end
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE) && !cal_start;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign cal_valid = (state == DONE) && (op == CAL);
  assign cal_found = found_q;
  assign cal_tap   = ctap_q;

endmodule
